// File: rtl/hpdmc_wrpath_ddr16_if.sv
// Controller/FIFO-side and pad-side signals of the DDR16 write datapath, bundled per direction.
interface hpdmc_wrpath_ddr16_if;
  logic        write_start;
  logic        busy;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] d0;
  logic [15:0] d1;
  logic [1:0]  dm0;
  logic [1:0]  dm1;
  logic        dq_oe;
  logic        dqs_oe;
  logic        dqs_d0;
  logic        dqs_d1;
  logic        underrun;
  logic        underrun_clr;

  modport master (
    output write_start, wr_data, wr_mask, wr_valid, underrun_clr,
    input  busy, wr_ready, d0, d1, dm0, dm1, dq_oe, dqs_oe, dqs_d0, dqs_d1, underrun
  );

  modport slave (
    input  write_start, wr_data, wr_mask, wr_valid, underrun_clr,
    output busy, wr_ready, d0, d1, dm0, dm1, dq_oe, dqs_oe, dqs_d0, dqs_d1, underrun
  );
endinterface

// File: rtl/hpdmc_wrpath_ddr16.sv
// DDR16 write datapath: pulls BURST words per write, splits them into DDR beats, drives DQS/OE/DM.
// Optional HPDMC_WR_MASK_EN forwards wr_mask onto dm0/dm1 for accepted words.
module hpdmc_wrpath_ddr16 #(
  parameter int BURST  = 4,
  parameter int WR_LAT = 1
) (
  input logic                   sys_clk,
  input logic                   sys_rst_n,
  hpdmc_wrpath_ddr16_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, WAIT, PRE, DATA, POST} state_t;

  localparam logic [3:0] WORD_LAST = 4'(BURST - 1);
  localparam logic [3:0] LAT_LAST  = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] lat_cnt, lat_nxt;
  logic [3:0] word_cnt, word_nxt;
  logic       ready;
  logic [1:0] acc_dm0, acc_dm1;

`ifdef HPDMC_WR_MASK_EN
  assign acc_dm0 = bus.wr_mask[1:0];
  assign acc_dm1 = bus.wr_mask[3:2];
`else
  assign acc_dm0 = 2'b00;
  assign acc_dm1 = 2'b00;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      lat_cnt  <= 4'd0;
      word_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      word_cnt <= word_nxt;
    end
  end

  // The last DATA cycle only drains the word fetched one cycle earlier, so it does not fetch.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    word_nxt  = word_cnt;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.write_start) begin
          lat_nxt   = 4'd0;
          word_nxt  = 4'd0;
          state_nxt = (WR_LAT == 1) ? PRE : WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) state_nxt = PRE;
        else                     lat_nxt   = lat_cnt + 4'd1;
      end
      PRE: begin
        ready     = 1'b1;
        word_nxt  = 4'd0;
        state_nxt = DATA;
      end
      DATA: begin
        if (word_cnt == WORD_LAST) begin
          state_nxt = POST;
        end else begin
          ready    = 1'b1;
          word_nxt = word_cnt + 4'd1;
        end
      end
      POST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.wr_ready = ready;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.busy     <= 1'b0;
      bus.dq_oe    <= 1'b0;
      bus.dqs_oe   <= 1'b0;
      bus.dqs_d0   <= 1'b0;
      bus.dqs_d1   <= 1'b0;
      bus.d0       <= 16'h0000;
      bus.d1       <= 16'h0000;
      bus.dm0      <= 2'b00;
      bus.dm1      <= 2'b00;
      bus.underrun <= 1'b0;
    end else begin
      bus.busy   <= (state_nxt != IDLE);
      bus.dqs_oe <= (state_nxt == PRE) || (state_nxt == DATA) || (state_nxt == POST);
      bus.dq_oe  <= (state_nxt == DATA);
      bus.dqs_d0 <= (state_nxt == DATA);
      bus.dqs_d1 <= 1'b0;
      if (ready && bus.wr_valid) begin
        bus.d0  <= bus.wr_data[15:0];
        bus.d1  <= bus.wr_data[31:16];
        bus.dm0 <= acc_dm0;
        bus.dm1 <= acc_dm1;
      end else if (ready) begin
        bus.d0  <= 16'h0000;
        bus.d1  <= 16'h0000;
        bus.dm0 <= 2'b11;
        bus.dm1 <= 2'b11;
      end else begin
        bus.d0  <= 16'h0000;
        bus.d1  <= 16'h0000;
        bus.dm0 <= 2'b00;
        bus.dm1 <= 2'b00;
      end
      if (bus.underrun_clr)             bus.underrun <= 1'b0;
      else if (ready && !bus.wr_valid)  bus.underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hpdmc_wrpath_ddr16.sv
// Directed bench for hpdmc_wrpath_ddr16: FIFO model plus slot scoreboard, WR_LAT=1 and WR_LAT=3 instances.
module tb_hpdmc_wrpath_ddr16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_b_n;

  hpdmc_wrpath_ddr16_if bus_a ();
  hpdmc_wrpath_ddr16_if bus_b ();

  hpdmc_wrpath_ddr16 #(.BURST(4), .WR_LAT(1)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_a)
  );

  hpdmc_wrpath_ddr16 #(.BURST(4), .WR_LAT(3)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_b_n),
    .bus       (bus_b)
  );

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  dm0;
    logic [1:0]  dm1;
  } slot_t;

  logic [35:0] fifo_q[$];
  slot_t       sb_q[$];
  int n_check = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int words_a = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t exp_slot(input logic [35:0] w);
    slot_t s;
    s.d0 = w[15:0];
    s.d1 = w[31:16];
`ifdef HPDMC_WR_MASK_EN
    s.dm0 = w[33:32];
    s.dm1 = w[35:34];
`else
    s.dm0 = 2'b00;
    s.dm1 = 2'b00;
`endif
    return s;
  endfunction

  // Book the slot fetched this cycle, advance one clock, then score whatever the pads show.
  task automatic tick();
    slot_t s;
    if (bus_a.wr_ready === 1'b1) begin
      if (bus_a.wr_valid) begin
        s = exp_slot(fifo_q.pop_front());
        words_a++;
      end else begin
        s = {16'h0000, 16'h0000, 2'b11, 2'b11};
      end
      sb_q.push_back(s);
    end
    @(posedge clk);
    #1;
    bus_a.write_start  = 1'b0;
    bus_a.underrun_clr = 1'b0;
    bus_b.write_start  = 1'b0;
    if (bus_a.dq_oe === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_check++;
        n_fail++;
        $error("FAIL unexpected_slot: observed d0=%0h with no slot expected", bus_a.d0);
      end else begin
        s = sb_q.pop_front();
        check("slot_d0",  32'(bus_a.d0),  32'(s.d0));
        check("slot_d1",  32'(bus_a.d1),  32'(s.d1));
        check("slot_dm0", 32'(bus_a.dm0), 32'(s.dm0));
        check("slot_dm1", 32'(bus_a.dm1), 32'(s.dm1));
      end
    end
    if (fifo_q.size() > 0) begin
      bus_a.wr_valid = 1'b1;
      bus_a.wr_data  = fifo_q[0][31:0];
      bus_a.wr_mask  = fifo_q[0][35:32];
    end else begin
      bus_a.wr_valid = 1'b0;
      bus_a.wr_data  = 32'h0;
      bus_a.wr_mask  = 4'h0;
    end
  endtask

  task automatic push_burst(input logic [3:0] mask1);
    fifo_q.push_back({4'b0000, 32'h1111_0000});
    fifo_q.push_back({mask1,   32'h3333_2222});
    fifo_q.push_back({4'b0000, 32'h5555_4444});
    fifo_q.push_back({4'b0000, 32'h7777_6666});
  endtask

  initial begin
    bus_a.write_start = 1'b0; bus_a.wr_data = 32'h0; bus_a.wr_mask = 4'h0;
    bus_a.wr_valid = 1'b0;    bus_a.underrun_clr = 1'b0;
    bus_b.write_start = 1'b0; bus_b.wr_data = 32'hcafe_f00d; bus_b.wr_mask = 4'h0;
    bus_b.wr_valid = 1'b1;    bus_b.underrun_clr = 1'b0;
    rst_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst_b_n = 1'b1;

    // Idle after reset
    repeat (20) tick();
    check("idle_busy",     32'(bus_a.busy),     32'd0);
    check("idle_wr_ready", 32'(bus_a.wr_ready), 32'd0);
    check("idle_d0",       32'(bus_a.d0),       32'd0);
    check("idle_d1",       32'(bus_a.d1),       32'd0);
    check("idle_dm0",      32'(bus_a.dm0),      32'd0);
    check("idle_dm1",      32'(bus_a.dm1),      32'd0);
    check("idle_dq_oe",    32'(bus_a.dq_oe),    32'd0);
    check("idle_dqs_oe",   32'(bus_a.dqs_oe),   32'd0);
    check("idle_dqs_d0",   32'(bus_a.dqs_d0),   32'd0);
    check("idle_dqs_d1",   32'(bus_a.dqs_d1),   32'd0);
    check("idle_underrun", 32'(bus_a.underrun), 32'd0);
    check("idle_b_busy",   32'(bus_b.busy),     32'd0);
    check("idle_b_ready",  32'(bus_b.wr_ready), 32'd0);

    // Clean burst, WR_LAT=1
    push_burst(4'b0000);
    tick();
    bus_a.write_start = 1'b1;
    tick();
    check("pre_dqs_oe",   32'(bus_a.dqs_oe),   32'd1);
    check("pre_dq_oe",    32'(bus_a.dq_oe),    32'd0);
    check("pre_dqs_d0",   32'(bus_a.dqs_d0),   32'd0);
    check("pre_busy",     32'(bus_a.busy),     32'd1);
    check("pre_wr_ready", 32'(bus_a.wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("data_dq_oe",  32'(bus_a.dq_oe),  32'd1);
      check("data_dqs_d0", 32'(bus_a.dqs_d0), 32'd1);
      check("data_dqs_d1", 32'(bus_a.dqs_d1), 32'd0);
    end
    tick();
    check("post_dq_oe",  32'(bus_a.dq_oe),  32'd0);
    check("post_dqs_oe", 32'(bus_a.dqs_oe), 32'd1);
    check("post_dqs_d0", 32'(bus_a.dqs_d0), 32'd0);
    check("post_busy",   32'(bus_a.busy),   32'd1);
    tick();
    check("end_busy",   32'(bus_a.busy),   32'd0);
    check("end_dqs_oe", 32'(bus_a.dqs_oe), 32'd0);
    check("burst_words", 32'(words_a),     32'd4);
    check("burst_sb_drained", 32'(sb_q.size()), 32'd0);

    // Third word missing -> underrun slot
    words_a = 0;
    push_burst(4'b0000);
    tick();
    bus_a.write_start = 1'b1;
    tick();
    tick();
    tick();
    bus_a.wr_valid = 1'b0;
    check("ur_before", 32'(bus_a.underrun), 32'd0);
    tick();
    check("ur_set", 32'(bus_a.underrun), 32'd1);
    tick();
    tick();
    check("ur_post_dq_oe",  32'(bus_a.dq_oe),  32'd0);
    check("ur_post_dqs_oe", 32'(bus_a.dqs_oe), 32'd1);
    tick();
    check("ur_end_busy", 32'(bus_a.busy),     32'd0);
    check("ur_sticky",   32'(bus_a.underrun), 32'd1);
    check("ur_words",    32'(words_a),        32'd3);
    fifo_q.delete();
    tick();
    bus_a.underrun_clr = 1'b1;
    tick();
    check("ur_cleared", 32'(bus_a.underrun), 32'd0);

    // write_start during a burst is ignored; back-to-back start after POST; masked word
    words_a = 0;
    push_burst(4'b0000);
    tick();
    bus_a.write_start = 1'b1;
    tick();
    tick();
    tick();
    bus_a.write_start = 1'b1;
    tick();
    check("ign_busy", 32'(bus_a.busy), 32'd1);
    tick();
    tick();
    check("ign_post_dq_oe",  32'(bus_a.dq_oe),  32'd0);
    check("ign_post_dqs_oe", 32'(bus_a.dqs_oe), 32'd1);
    check("ign_words",       32'(words_a),      32'd4);
    push_burst(4'b0110);
    tick();
    check("b2b_idle_busy", 32'(bus_a.busy), 32'd0);
    bus_a.write_start = 1'b1;
    tick();
    check("b2b_pre_dqs_oe", 32'(bus_a.dqs_oe), 32'd1);
    check("b2b_pre_dq_oe",  32'(bus_a.dq_oe),  32'd0);
    check("b2b_pre_busy",   32'(bus_a.busy),   32'd1);
    repeat (5) tick();
    check("b2b_post_dq_oe",  32'(bus_a.dq_oe),  32'd0);
    check("b2b_post_dqs_oe", 32'(bus_a.dqs_oe), 32'd1);
    tick();
    check("b2b_end_busy", 32'(bus_a.busy),      32'd0);
    check("b2b_words",    32'(words_a),         32'd8);
    check("b2b_sb_drained", 32'(sb_q.size()),   32'd0);

    // WR_LAT=3 instance, reset mid-burst
    tick();
    bus_b.write_start = 1'b1;
    tick();
    check("lat3_t1_busy",   32'(bus_b.busy),   32'd1);
    check("lat3_t1_dqs_oe", 32'(bus_b.dqs_oe), 32'd0);
    tick();
    check("lat3_t2_dqs_oe", 32'(bus_b.dqs_oe), 32'd0);
    tick();
    check("lat3_pre_dqs_oe", 32'(bus_b.dqs_oe),   32'd1);
    check("lat3_pre_dq_oe",  32'(bus_b.dq_oe),    32'd0);
    check("lat3_pre_ready",  32'(bus_b.wr_ready), 32'd1);
    tick();
    check("lat3_data_dq_oe", 32'(bus_b.dq_oe), 32'd1);
    rst_b_n = 1'b0;
    #1;
    check("rst_dq_oe",  32'(bus_b.dq_oe),    32'd0);
    check("rst_dqs_oe", 32'(bus_b.dqs_oe),   32'd0);
    check("rst_busy",   32'(bus_b.busy),     32'd0);
    check("rst_ready",  32'(bus_b.wr_ready), 32'd0);
    check("rst_d0",     32'(bus_b.d0),       32'd0);
    tick();
    rst_b_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("after_rst_ready",  32'(bus_b.wr_ready), 32'd0);
      check("after_rst_dqs_oe", 32'(bus_b.dqs_oe),   32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
